// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Execute-side partner of the fetch/decode/execute sequencer.
//               Latches the instruction on ir_load. When the sequencer is in
//               EXECUTE, runs the buffered instruction as a short multi-cycle
//               sequence and reports progress on cu_state. DONE (2'b11) lasts
//               one cycle and is the completion handshake. The block holds the
//               4 x DATA_WIDTH register file, the ALU, the Z/C flags and the
//               data-memory strobes.
// Ports       : clk, reset (async, active high)
//               current_state[1:0]  sequencer state (00 FETCH, 01 DECODE, 10 EXECUTE)
//               ir_load, instr[7:0] instruction capture ({opcode, rd, rs})
//               mem_rdata           read data, valid the cycle after mem_read
//               dbg_sel, dbg_data   combinational register-file debug read
//               cu_state            00 IDLE, 01 OPERAND, 10 WRITEBACK, 11 DONE
//               mem_read/mem_write/mem_addr/mem_wdata  registered memory port
//               zero_flag, carry_flag, illegal_op (sticky)
// Revision    : 1.0  initial release
// ============================================================================
module control_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            current_state,
    input  logic                  ir_load,
    input  logic [7:0]            instr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [1:0]            dbg_sel,
    output logic [1:0]            cu_state,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic                  illegal_op,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_OPERAND   = 2'b01,
        ST_WRITEBACK = 2'b10,
        ST_DONE      = 2'b11
    } state_t;

    localparam logic [1:0] c_SEQ_EXECUTE = 2'b10;

    localparam logic [3:0] c_NOP = 4'b0000;
    localparam logic [3:0] c_ADD = 4'b0001;
    localparam logic [3:0] c_SUB = 4'b0010;
    localparam logic [3:0] c_AND = 4'b0011;
    localparam logic [3:0] c_OR  = 4'b0100;
    localparam logic [3:0] c_XOR = 4'b0101;
    localparam logic [3:0] c_INC = 4'b0110;
    localparam logic [3:0] c_MOV = 4'b0111;
    localparam logic [3:0] c_LD  = 4'b1000;
    localparam logic [3:0] c_ST  = 4'b1001;
    localparam logic [3:0] c_CLR = 4'b1010;

    state_t                r_state;
    logic [7:0]            r_ibuf;
    logic                  r_pending;
    logic [3:0]            r_op;
    logic [1:0]            r_rd;
    logic [DATA_WIDTH-1:0] r_opa;
    logic [DATA_WIDTH-1:0] r_opb;
    logic [DATA_WIDTH-1:0] r_regs [4];
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_zero;
    logic                  r_carry;
    logic                  r_illegal;

    // Decode of the buffered instruction, used only on the start edge
    logic [3:0]            w_bop;
    logic [DATA_WIDTH-1:0] w_rd_val;
    logic [DATA_WIDTH-1:0] w_rs_val;
    logic                  w_start;
    logic                  w_legal;

    assign w_bop    = r_ibuf[7:4];
    assign w_rd_val = r_regs[r_ibuf[3:2]];
    assign w_rs_val = r_regs[r_ibuf[1:0]];
    assign w_start  = (r_state == ST_IDLE) && r_pending && (current_state == c_SEQ_EXECUTE);
    assign w_legal  = (w_bop <= c_CLR);

    // ALU result for the op in flight, consumed on the edge ending WRITEBACK
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_cout;
    logic                  w_wr_reg;
    logic                  w_upd_flags;

    always_comb begin
        w_res       = '0;
        w_cout      = 1'b0;
        w_wr_reg    = 1'b0;
        w_upd_flags = 1'b0;
        case (r_op)
            c_ADD: begin
                {w_cout, w_res} = {1'b0, r_opa} + {1'b0, r_opb};
                w_wr_reg = 1'b1; w_upd_flags = 1'b1;
            end
            c_SUB: begin
                // Top bit of the widened difference is the borrow (rd < rs)
                {w_cout, w_res} = {1'b0, r_opa} - {1'b0, r_opb};
                w_wr_reg = 1'b1; w_upd_flags = 1'b1;
            end
            c_AND: begin w_res = r_opa & r_opb; w_wr_reg = 1'b1; w_upd_flags = 1'b1; end
            c_OR:  begin w_res = r_opa | r_opb; w_wr_reg = 1'b1; w_upd_flags = 1'b1; end
            c_XOR: begin w_res = r_opa ^ r_opb; w_wr_reg = 1'b1; w_upd_flags = 1'b1; end
            c_INC: begin
                {w_cout, w_res} = {1'b0, r_opa} + {{DATA_WIDTH{1'b0}}, 1'b1};
                w_wr_reg = 1'b1; w_upd_flags = 1'b1;
            end
            c_MOV: begin w_res = r_opb;     w_wr_reg = 1'b1; end
            c_LD:  begin w_res = mem_rdata; w_wr_reg = 1'b1; end
            c_CLR: begin w_res = '0;        w_wr_reg = 1'b1; end
            default: begin
                w_res = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ibuf      <= '0;
            r_pending   <= 1'b0;
            r_op        <= '0;
            r_rd        <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            // A capture in the start cycle wins over the start's clear, so a
            // back-to-back instruction stays pending.
            if (w_start) r_pending <= 1'b0;
            if (ir_load) begin
                r_ibuf    <= instr;
                r_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_op  <= w_bop;
                        r_rd  <= r_ibuf[3:2];
                        r_opa <= w_rd_val;
                        r_opb <= w_rs_val;
                        if (!w_legal) begin
                            r_illegal <= 1'b1;
                            r_state   <= ST_DONE;
                        end else if (w_bop == c_NOP) begin
                            r_state   <= ST_DONE;
                        end else begin
                            r_state   <= ST_OPERAND;
                        end
                        // Strobes are launched here so they are high for T1 only
                        if (w_bop == c_LD) begin
                            r_mem_read <= 1'b1;
                            r_mem_addr <= w_rs_val[ADDR_WIDTH-1:0];
                        end
                        if (w_bop == c_ST) begin
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= w_rs_val[ADDR_WIDTH-1:0];
                            r_mem_wdata <= w_rd_val;
                        end
                    end
                end
                ST_OPERAND: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_state     <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    if (w_wr_reg) r_regs[r_rd] <= w_res;
                    if (w_upd_flags) begin
                        r_zero  <= (w_res == '0);
                        r_carry <= w_cout;
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cu_state   = r_state;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign zero_flag  = r_zero;
    assign carry_flag = r_carry;
    assign illegal_op = r_illegal;
    assign dbg_data   = r_regs[dbg_sel];

endmodule
`default_nettype wire
